arb_dispatch: RTL and testbench

Routes a single stream of `arb_struct_t` transactions to one of `SINKS` destination ports, chosen by a destination index supplied with each transaction. It is the fan-out counterpart of the arbiter's many-to-one merge, and sits where one arbitrated stream must be redistributed to multiple consumers. Each sink has a one-entry output slot, so a stalled sink blocks only traffic addressed to it. Transactions with an invalid destination are dropped and flagged, never stalled.

---
 rtl/arb_pkg.sv | 31 +++
 rtl/arb_dispatch_slot.sv | 30 +++
 rtl/arb_dispatch.sv | 87 ++++++++
 tb/tb_arb_dispatch.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared arbiter/dispatch types: transaction payload, arbitration mode and
// the destination-index width helper used to size port index buses.
package arb_pkg;

  localparam int ARB_SRC_W     = 4;
  localparam int ARB_PAYLOAD_W = 16;

  // One transaction flowing through the arbiter and the dispatcher.
  typedef struct packed {
    logic [ARB_SRC_W-1:0]     src_id;
    logic [ARB_PAYLOAD_W-1:0] payload;
  } arb_struct_t;

  // Arbitration policy used by the many-to-one merge side.
  typedef enum logic [1:0] {
    ARB_MODE_RR    = 2'd0,
    ARB_MODE_FIXED = 2'd1,
    ARB_MODE_LRU   = 2'd2
  } arb_mode_t;

  // Index width for n ports; never narrower than one bit so a single-port
  // instance still has an index that can express the out-of-range value 1.
  function automatic int dest_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/arb_dispatch_slot.sv
// One-entry output slot: a full bit and a data register. A load wins over a
// drain in the same cycle so a continuously draining sink sees no bubble.
module arb_dispatch_slot
  import arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  arb_struct_t load_data,
  input  logic        drain,
  output logic        full,
  output arb_struct_t data
);

  // Slot state: reset empties, load fills (even while draining), drain empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      data <= load_data;
    end else if (full && drain) begin
      full <= 1'b0;
    end else begin
      full <= full;
    end
  end

endmodule

// File: rtl/arb_dispatch.sv
// Fan-out of one transaction stream to SINKS one-entry output slots selected
// by in_dest. Out-of-range destinations are consumed, flagged and counted.
module arb_dispatch
  import arb_pkg::*;
#(
  parameter int SINKS = 4,
  parameter int DW    = dest_width(SINKS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  arb_struct_t       in_data,
  input  logic [DW-1:0]     in_dest,
  output logic [SINKS-1:0]  out_valid,
  input  logic [SINKS-1:0]  out_ready,
  output arb_struct_t       out_data [SINKS],
  output logic              err_dest,
  output logic [7:0]        err_count,
  output logic              busy
);

  logic [SINKS-1:0] sel_s;
  logic [SINKS-1:0] load_s;
  logic             dest_valid_s;
  logic             slot_free_s;
  logic             accept_s;
  logic             drop_s;

  // One-hot decode of in_dest; an out-of-range index decodes to all zeros.
  always_comb begin
    sel_s = '0;
    for (int k = 0; k < SINKS; k++) begin
      if (in_dest == DW'(k)) begin
        sel_s[k] = 1'b1;
      end else begin
        sel_s[k] = 1'b0;
      end
    end
  end

  assign dest_valid_s = |sel_s;
  assign slot_free_s  = |(sel_s & (~out_valid | out_ready));

  // Ready mux: the addressed slot must be empty or draining; drops never stall.
  always_comb begin
    in_ready = 1'b1;
    if (dest_valid_s) begin
      in_ready = slot_free_s;
    end else begin
      in_ready = 1'b1;
    end
  end

  assign accept_s = in_valid && in_ready;
  assign drop_s   = accept_s && !dest_valid_s;
  assign load_s   = sel_s & {SINKS{accept_s}};
  assign busy     = |out_valid;

  for (genvar k = 0; k < SINKS; k++) begin : g_slot
    arb_dispatch_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load_s[k]),
      .load_data (in_data),
      .drain     (out_ready[k]),
      .full      (out_valid[k]),
      .data      (out_data[k])
    );
  end

  // Error pulse one cycle after a drop, and a count of drops stuck at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_dest  <= 1'b0;
      err_count <= 8'd0;
    end else begin
      err_dest <= drop_s;
      if (drop_s && (err_count != 8'd255)) begin
        err_count <= err_count + 8'd1;
      end else begin
        err_count <= err_count;
      end
    end
  end

endmodule

// File: tb/tb_arb_dispatch.sv
// Directed bench for arb_dispatch: a 4-sink instance for routing, stall and
// reset behaviour, and a 3-sink instance where index 3 is out of range.
module tb_arb_dispatch;
  import arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // 4-sink instance
  logic        v4, r4, e4, b4;
  arb_struct_t d4;
  logic [1:0]  dst4;
  logic [3:0]  ov4, or4;
  arb_struct_t od4 [4];
  logic [7:0]  ec4;

  // 3-sink instance
  logic        v3, r3, e3, b3;
  arb_struct_t d3;
  logic [1:0]  dst3;
  logic [2:0]  ov3, or3;
  arb_struct_t od3 [3];
  logic [7:0]  ec3;

  arb_dispatch #(.SINKS(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4), .in_data(d4),
    .in_dest(dst4), .out_valid(ov4), .out_ready(or4), .out_data(od4),
    .err_dest(e4), .err_count(ec4), .busy(b4)
  );

  arb_dispatch #(.SINKS(3)) u3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(r3), .in_data(d3),
    .in_dest(dst3), .out_valid(ov3), .out_ready(or3), .out_data(od3),
    .err_dest(e3), .err_count(ec3), .busy(b3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam arb_struct_t PA = {4'hA, 16'h1234};
  localparam arb_struct_t PB = {4'hB, 16'h5678};
  localparam arb_struct_t PD = {4'h3, 16'hD00D};
  localparam arb_struct_t PE = {4'h4, 16'hE00E};
  localparam arb_struct_t PF = {4'h5, 16'hF00F};
  localparam arb_struct_t PG = {4'h6, 16'h6006};
  localparam arb_struct_t PX = {4'h7, 16'h7777};

  initial begin
    rst = 1'b1;
    v4 = 1'b0; d4 = '0; dst4 = 2'd0; or4 = 4'b0000;
    v3 = 1'b0; d3 = '0; dst3 = 2'd0; or3 = 3'b000;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(ov4), 32'h0);
    chk("rst_busy", 32'(b4), 32'h0);
    chk("rst_err_dest", 32'(e4), 32'h0);
    chk("rst_err_count", 32'(ec4), 32'h0);
    chk("rst_out_data2", 32'(od4[2]), 32'h0);

    // single transfer to a stalled sink 2
    v4 = 1'b1; dst4 = 2'd2; d4 = PA;
    #1;
    chk("a_in_ready", 32'(r4), 32'h1);
    tick();
    chk("a_out_valid", 32'(ov4), 32'h4);
    chk("a_out_data2", 32'(od4[2]), 32'(PA));
    chk("a_busy", 32'(b4), 32'h1);
    d4 = PB;
    #1;
    chk("b_blocked", 32'(r4), 32'h0);
    tick();
    chk("b_held_data", 32'(od4[2]), 32'(PA));
    or4 = 4'b0100;
    #1;
    chk("b_ready_drain", 32'(r4), 32'h1);
    tick();
    chk("b_refill_valid", 32'(ov4), 32'h4);
    chk("b_refill_data", 32'(od4[2]), 32'(PB));
    v4 = 1'b0;
    tick();
    chk("b_drained", 32'(ov4), 32'h0);

    // back-to-back stream into sink 1
    or4 = 4'b0010; dst4 = 2'd1;
    for (int i = 0; i < 4; i++) begin
      v4 = 1'b1; d4 = arb_struct_t'(20'hC0000 + 20'(i));
      #1;
      chk("s_in_ready", 32'(r4), 32'h1);
      tick();
      chk("s_out_valid1", 32'(ov4[1]), 32'h1);
      chk("s_out_data1", 32'(od4[1]), 32'h000C0000 + 32'(i));
    end
    v4 = 1'b0;
    tick();
    chk("s_drained", 32'(ov4), 32'h0);

    // sink 0 stalled and full while traffic flows to sinks 1 and 3
    or4 = 4'b0000; v4 = 1'b1; dst4 = 2'd0; d4 = PD;
    tick();
    or4 = 4'b1010; dst4 = 2'd1; d4 = PE;
    #1;
    chk("h_ready_e", 32'(r4), 32'h1);
    tick();
    dst4 = 2'd3; d4 = PF;
    #1;
    chk("h_ready_f", 32'(r4), 32'h1);
    tick();
    chk("h_data3", 32'(od4[3]), 32'(PF));
    dst4 = 2'd1; d4 = PG;
    #1;
    chk("h_ready_g", 32'(r4), 32'h1);
    tick();
    chk("h_valid", 32'(ov4), 32'h3);
    chk("h_data0", 32'(od4[0]), 32'(PD));
    chk("h_data1", 32'(od4[1]), 32'(PG));
    v4 = 1'b0; or4 = 4'b0001;
    tick();
    chk("h_valid_after0", 32'(ov4), 32'h2);
    or4 = 4'b1111;
    tick();
    chk("h_all_drained", 32'(ov4), 32'h0);
    chk("h_no_err", 32'(ec4), 32'h0);

    // out-of-range destination on the 3-sink instance
    v3 = 1'b1; dst3 = 2'd3; d3 = PX;
    #1;
    chk("e_in_ready", 32'(r3), 32'h1);
    tick();
    v3 = 1'b0;
    chk("e_pulse", 32'(e3), 32'h1);
    chk("e_count1", 32'(ec3), 32'h1);
    chk("e_no_valid", 32'(ov3), 32'h0);
    tick();
    chk("e_pulse_end", 32'(e3), 32'h0);
    v3 = 1'b1;
    for (int i = 0; i < 299; i++) begin
      tick();
    end
    v3 = 1'b0;
    chk("e_saturate", 32'(ec3), 32'd255);
    tick();
    chk("e_still_sat", 32'(ec3), 32'd255);

    // reset drops held contents of slots 0 and 2
    or4 = 4'b0000; v4 = 1'b1; dst4 = 2'd0; d4 = PA;
    tick();
    dst4 = 2'd2; d4 = PB;
    tick();
    v4 = 1'b0;
    chk("r_pre_valid", 32'(ov4), 32'h5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_valid", 32'(ov4), 32'h0);
    chk("r_busy", 32'(b4), 32'h0);
    chk("r_data0", 32'(od4[0]), 32'h0);
    chk("r_data2", 32'(od4[2]), 32'h0);
    chk("r_err_count3", 32'(ec3), 32'h0);
    or4 = 4'b1111;
    tick(); tick();
    chk("r_no_delivery", 32'(ov4), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
